// File: rtl/uart_top_rx_pkg.sv
// uart_top_rx_pkg -- shared UART encodings: FSM states and oversampling constants.
// Revision 1.0
`default_nettype none
package uart_top_rx_pkg;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   localparam int         OVERSAMPLE = 16;
   localparam logic [3:0] MID_TICK   = 4'd7;
   localparam logic [3:0] LAST_TICK  = 4'(OVERSAMPLE - 1);
endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
// uart_baud_gen -- free-running tick generator, one s_tick every dvsr+1 clocks.
// Revision 1.0
`default_nettype none
module uart_baud_gen #(
   parameter int DVSR_W = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DVSR_W-1:0] dvsr,
   output logic              s_tick
);
   logic [DVSR_W-1:0] cnt_q, cnt_d;

   // A counter already past a newly lowered dvsr runs on to all-ones and wraps.
   always_comb begin
      cnt_d = (cnt_q == dvsr) ? '0 : cnt_q + 1'b1;
   end

   assign s_tick = (cnt_q == dvsr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
endmodule
`default_nettype wire

// File: rtl/uart_top_rx.sv
// uart_top_rx -- 8N1 UART receiver, 16x oversampled, with stop-bit check.
// Revision 1.0
`default_nettype none
module uart_top_rx
   import uart_top_rx_pkg::*;
#(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int DVSR_W  = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_in,
   input  logic [DVSR_W-1:0] dvsr,
   output logic [DBIT-1:0]   d_out,
   output logic              rx_done,
   output logic              frame_err
);
   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

   logic [1:0]      sync_q;
   logic            rx_s;
   logic            s_tick;
   logic [1:0]      state_q, state_d;
   logic [3:0]      s_q, s_d;
   logic [NW-1:0]   n_q, n_d;
   logic [DBIT-1:0] b_q, b_d;
   logic [DBIT-1:0] dout_q, dout_d;
   logic            done_q, done_d;
   logic            ferr_q, ferr_d;

   uart_baud_gen #(.DVSR_W(DVSR_W)) u_baud (
      .clk    (clk),
      .rst_n  (rst_n),
      .dvsr   (dvsr),
      .s_tick (s_tick)
   );

   assign rx_s = sync_q[1];

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      b_d     = b_q;
      dout_d  = dout_q;
      ferr_d  = ferr_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!rx_s) begin
               state_d = ST_START;
               s_d     = '0;
            end
         end
         ST_START: begin
            if (s_tick) begin
               if (s_q == MID_TICK) begin
                  // Line back high at mid start bit means a glitch, not a frame.
                  state_d = rx_s ? ST_IDLE : ST_DATA;
                  s_d     = '0;
                  n_d     = '0;
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (s_tick) begin
               if (s_q == LAST_TICK) begin
                  s_d = '0;
                  b_d = {rx_s, b_q[DBIT-1:1]};
                  if (n_q == NW'(DBIT - 1)) state_d = ST_STOP;
                  else                      n_d     = n_q + 1'b1;
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         default: begin
            if (s_tick) begin
               if (s_q == 4'(SB_TICK - 1)) begin
                  state_d = ST_IDLE;
                  dout_d  = b_q;
                  ferr_d  = ~rx_s;
                  done_d  = 1'b1;
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= 2'b11;
         state_q <= ST_IDLE;
         s_q     <= '0;
         n_q     <= '0;
         b_q     <= '0;
         dout_q  <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], rx_in};
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         b_q     <= b_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
      end
   end

   assign d_out     = dout_q;
   assign rx_done   = done_q;
   assign frame_err = ferr_q;
endmodule
`default_nettype wire
